// File: rtl/aes128_cipher_core_pkg.sv
// Shared definitions for the AES-128 cipher core.
// Purpose: round count, FSM state encoding, byte-order helpers and the
//          GF(2^8) / MixColumns / ShiftRows functions used by the datapath.
// Ports:   none (package).
package aes128_cipher_core_pkg;

  // AES-128 is the only supported key size, so the round count is fixed.
  localparam int NR_AES128   = 10;
  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Byte idx of a block lives at bits [127-8*idx -: 8]; state s[r][c] is byte r+4c.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // One column {a0,a1,a2,a3} (a0 = row 0, most significant) times the
  // circulant matrix {02,03,01,01}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return res;
  endfunction

  // A column is four consecutive bytes, i.e. one 32-bit slice of the block.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes128_cipher_core_sbox.sv
// Forward AES S-box, purely combinational 256-entry lookup.
// Purpose: SubBytes for one byte; reusable by the key expansion block.
// Ports:
//   value   input  8  byte to substitute
//   result  output 8  S-box image of value
module aes128_cipher_core_sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);

  // Row-major table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = SBOX_TABLE[(255 - int'(value))*8 +: 8];

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core, one round per clock.
// Purpose: consumes a plaintext block plus the eleven expanded round keys,
//          runs ten rounds over a single 128-bit state register and presents
//          the ciphertext under a valid/ready handshake.
// Ports:
//   CLK            input  1       rising-edge clock
//   RST            input  1       synchronous active-high reset
//   in_valid       input  1       plaintext and keys valid
//   in_ready       output 1       core idle, can accept a block
//   plaintext      input  128     block, byte 0 in [127:120]
//   key_0..key_10  input  128     round keys, held stable until output handshake
//   out_valid      output 1       ciphertext valid
//   out_ready      input  1       consumer takes ciphertext
//   ciphertext     output 128     result, same byte order as plaintext
module aes128_cipher_core
  import aes128_cipher_core_pkg::*;
#(
  parameter int NR           = 10,
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key_0,
  input  logic [127:0] key_1,
  input  logic [127:0] key_2,
  input  logic [127:0] key_3,
  input  logic [127:0] key_4,
  input  logic [127:0] key_5,
  input  logic [127:0] key_6,
  input  logic [127:0] key_7,
  input  logic [127:0] key_8,
  input  logic [127:0] key_9,
  input  logic [127:0] key_10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes128_cipher_core supports only NR = 10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_key;
  logic [127:0] round_out;

  for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_sbox
    aes128_cipher_core_sbox u_sbox (
      .value  (state_q[127-8*i -: 8]),
      .result (sub_bytes[127-8*i -: 8])
    );
  end

  assign shifted = shift_rows(sub_bytes);
  assign mixed   = mix_columns(shifted);

  // Keys are not captured; the round counter selects the live key input.
  always_comb begin
    round_key = '0;
    case (round_q)
      4'd0:    round_key = key_0;
      4'd1:    round_key = key_1;
      4'd2:    round_key = key_2;
      4'd3:    round_key = key_3;
      4'd4:    round_key = key_4;
      4'd5:    round_key = key_5;
      4'd6:    round_key = key_6;
      4'd7:    round_key = key_7;
      4'd8:    round_key = key_8;
      4'd9:    round_key = key_9;
      4'd10:   round_key = key_10;
      default: round_key = '0;
    endcase
  end

  // The final round skips MixColumns.
  assign round_out = ((round_q == LAST_ROUND) ? shifted : mixed) ^ round_key;

  // Next-state logic. A round count outside 1..NR while running can only come
  // from corruption, so the block is dropped rather than presented.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) fsm_d = ST_RUN;
      end
      ST_RUN: begin
        if (round_q == 4'd0 || round_q > LAST_ROUND) fsm_d = ST_IDLE;
        else if (round_q == LAST_ROUND)               fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (fsm_q == ST_IDLE);
  assign out_valid  = (fsm_q == ST_DONE);
  assign ciphertext = (ZERO_ON_IDLE && !out_valid) ? '0 : state_q;

  // State register, round counter and FSM. The counter returns to zero as the
  // last round completes so that it never holds a value above NR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= plaintext ^ key_0;
            round_q <= 4'd1;
          end
        end
        ST_RUN: begin
          if (round_q == 4'd0 || round_q > LAST_ROUND) begin
            round_q <= 4'd0;
          end else begin
            state_q <= round_out;
            round_q <= (round_q == LAST_ROUND) ? 4'd0 : round_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Self-checking bench for aes128_cipher_core: FIPS-197 vectors, latency,
// backpressure, mid-block reset and back-to-back operation.
module tb_aes128_cipher_core;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] S1_0 = 128'h00102030405060708090a0b0c0d0e0f0;

  localparam logic [2047:0] SBOX_REF = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] rk [0:10];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_count  = 0;

  aes128_cipher_core dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_0      (rk[0]),
    .key_1      (rk[1]),
    .key_2      (rk[2]),
    .key_3      (rk[3]),
    .key_4      (rk[4]),
    .key_5      (rk[5]),
    .key_6      (rk[6]),
    .key_7      (rk[7]),
    .key_8      (rk[8]),
    .key_9      (rk[9]),
    .key_10     (rk[10]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle_count++;

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    return SBOX_REF[(255 - int'(b))*8 +: 8];
  endfunction

  // Reference AES-128 key schedule feeding the eleven round-key inputs.
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Presents one block; returns just after the accept edge.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key, input bit hold_valid);
    expand_key(key);
    plaintext = pt;
    in_valid  = 1'b1;
    checkOutput("ready_before_accept", {127'd0, in_ready}, 128'd1);
    step();
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    checkOutput({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
  endtask

  initial begin
    int lat;
    int rise1;
    int rise2;
    bit ready_low;
    bit stable;

    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    expand_key('0);
    step();
    step();
    checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("reset_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("reset_ciphertext", ciphertext, 128'd0);
    RST = 1'b0;
    step();

    // Vector 1: initial AddRoundKey, latency, busy flag, then backpressure.
    applyStimulus(PT1, KEY1, 1'b0);
    checkOutput("v1_state_after_accept", dut.state_q, S1_0);
    lat = 0;
    ready_low = 1'b1;
    while (!out_valid && lat < 30) begin
      if (in_ready) ready_low = 1'b0;
      step();
      lat++;
    end
    checkOutput("v1_latency", 128'(lat), 128'd10);
    checkOutput("v1_ready_low_while_busy", {127'd0, ready_low}, 128'd1);
    checkOutput("v1_ciphertext", ciphertext, CT1);

    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!out_valid || ciphertext !== CT1 || in_ready) stable = 1'b0;
    end
    checkOutput("bp_held_stable", {127'd0, stable}, 128'd1);
    out_ready = 1'b1;
    step();
    checkOutput("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("bp_release_ct_zero", ciphertext, 128'd0);

    // Vector 2 with out_ready held high: DONE lasts one cycle.
    applyStimulus(PT2, KEY2, 1'b0);
    wait_out_valid("v2", lat);
    checkOutput("v2_latency", 128'(lat), 128'd10);
    checkOutput("v2_ciphertext", ciphertext, CT2);
    step();
    checkOutput("v2_done_one_cycle", {127'd0, out_valid}, 128'd0);

    // Reset while round 5 is pending, then a clean run.
    applyStimulus(PT1, KEY1, 1'b0);
    repeat (4) step();
    checkOutput("abort_round_is_5", {124'd0, dut.round_q}, 128'd5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("abort_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("abort_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("abort_ciphertext", ciphertext, 128'd0);
    applyStimulus(PT2, KEY2, 1'b0);
    wait_out_valid("post_abort", lat);
    checkOutput("post_abort_ciphertext", ciphertext, CT2);
    step();

    // Back-to-back with in_valid held high; block 2 data appears once block 1 is taken.
    applyStimulus(PT1, KEY1, 1'b1);
    wait_out_valid("b2b_1", lat);
    rise1 = cycle_count;
    checkOutput("b2b_ct1", ciphertext, CT1);
    step();
    checkOutput("b2b_idle_ready", {127'd0, in_ready}, 128'd1);
    plaintext = PT2;
    expand_key(KEY2);
    wait_out_valid("b2b_2", lat);
    rise2 = cycle_count;
    in_valid = 1'b0;
    checkOutput("b2b_ct2", ciphertext, CT2);
    checkOutput("b2b_spacing", 128'(rise2 - rise1), 128'd12);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
